// File: rtl/life_engine.sv
// Conway's Life engine: evaluates one cell per cycle over a GRID_W x GRID_H bit grid
// and streams every changed cell out as a pixel write with valid/ready handshake.
module life_engine #(
  parameter int         GRID_W       = 160,
  parameter int         GRID_H       = 120,
  parameter logic [2:0] ALIVE_COLOUR = 3'b111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [0:0]  load_val,
  input  logic        clear,
  input  logic        step,
  input  logic        run,
  input  logic        wrap,
  output logic [7:0]  out_x,
  output logic [7:0]  out_y,
  output logic [2:0]  colour,
  output logic        plot,
  input  logic        plot_ready,
  output logic        busy,
  output logic [15:0] gen_count,
  output logic [15:0] alive_count
);
  localparam int         N_CELLS = GRID_W * GRID_H;
  localparam int         IDX_W   = $clog2(N_CELLS);
  localparam logic [7:0] X_MAX   = 8'(GRID_W - 1);
  localparam logic [7:0] Y_MAX   = 8'(GRID_H - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [N_CELLS-1:0] cur_q, cur_d, nxt_q, nxt_d;
  logic [7:0]         x_q, x_d, y_q, y_d;
  logic               wrap_q, wrap_d;
  logic               from_load_q, from_load_d;
  logic [7:0]         out_x_q, out_x_d, out_y_q, out_y_d;
  logic [2:0]         colour_q, colour_d;
  logic               plot_q, plot_d;
  logic [15:0]        gen_q, gen_d, alive_q, alive_d, alive_nxt_q, alive_nxt_d;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [7:0] cx, input logic [7:0] cy);
    return IDX_W'(int'(cy) * GRID_W + int'(cx));
  endfunction

  // Eight neighbour taps around the scan index; the centre slot is tied off.
  logic [8:0] nb_alive;
  for (genvar gi = 0; gi < 9; gi++) begin : g_nb
    if (gi == 4) begin : g_centre
      assign nb_alive[gi] = 1'b0;
    end else begin : g_tap
      localparam int DX = gi % 3 - 1;
      localparam int DY = gi / 3 - 1;
      logic [7:0] nx, ny;
      logic       nb_valid;
      always_comb begin
        nx       = x_q;
        ny       = y_q;
        nb_valid = 1'b1;
        if (DX < 0) begin
          if (x_q == 8'd0) begin nx = X_MAX; nb_valid = wrap_q; end
          else nx = x_q - 8'd1;
        end else if (DX > 0) begin
          if (x_q == X_MAX) begin nx = 8'd0; nb_valid = wrap_q; end
          else nx = x_q + 8'd1;
        end
        if (DY < 0) begin
          if (y_q == 8'd0) begin ny = Y_MAX; nb_valid = nb_valid & wrap_q; end
          else ny = y_q - 8'd1;
        end else if (DY > 0) begin
          if (y_q == Y_MAX) begin ny = 8'd0; nb_valid = nb_valid & wrap_q; end
          else ny = y_q + 8'd1;
        end
      end
      assign nb_alive[gi] = nb_valid & cur_q[cell_idx(nx, ny)];
    end
  end

  logic [3:0]       n_count;
  logic [IDX_W-1:0] scan_idx, load_idx;
  logic             cur_bit, new_val, last_cell, load_in_range;
  logic [7:0]       adv_x, adv_y;

  always_comb begin
    n_count = 4'd0;
    for (int i = 0; i < 9; i++) n_count = n_count + 4'(nb_alive[i]);
  end

  assign scan_idx      = cell_idx(x_q, y_q);
  assign load_idx      = cell_idx(x_in, y_in);
  assign cur_bit       = cur_q[scan_idx];
  assign new_val       = (n_count == 4'd3) | (cur_bit & (n_count == 4'd2));
  assign last_cell     = (x_q == X_MAX) && (y_q == Y_MAX);
  assign load_in_range = ({1'b0, x_in} < 9'(GRID_W)) && ({1'b0, y_in} < 9'(GRID_H));
  assign adv_x         = (x_q == X_MAX) ? 8'd0 : x_q + 8'd1;
  assign adv_y         = (x_q == X_MAX) ? y_q + 8'd1 : y_q;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    x_d         = x_q;
    y_d         = y_q;
    wrap_d      = wrap_q;
    from_load_d = from_load_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    colour_d    = colour_q;
    plot_d      = plot_q;
    gen_d       = gen_q;
    alive_d     = alive_q;
    alive_nxt_d = alive_nxt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          cur_d   = '0;
          nxt_d   = '0;
          gen_d   = 16'd0;
          alive_d = 16'd0;
        end else if (load) begin
          if (load_in_range) begin
            cur_d[load_idx] = load_val[0];
            if (cur_q[load_idx] != load_val[0])
              alive_d = load_val[0] ? alive_q + 16'd1 : alive_q - 16'd1;
            out_x_d     = x_in;
            out_y_d     = y_in;
            colour_d    = load_val[0] ? ALIVE_COLOUR : 3'b000;
            plot_d      = 1'b1;
            from_load_d = 1'b1;
            state_d     = EMIT;
          end
        end else if (step || run) begin
          wrap_d      = wrap;
          x_d         = 8'd0;
          y_d         = 8'd0;
          alive_nxt_d = alive_q;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        nxt_d[scan_idx] = new_val;
        if (new_val != cur_bit) begin
          alive_nxt_d = new_val ? alive_nxt_q + 16'd1 : alive_nxt_q - 16'd1;
          out_x_d     = x_q;
          out_y_d     = y_q;
          colour_d    = new_val ? ALIVE_COLOUR : 3'b000;
          plot_d      = 1'b1;
          from_load_d = 1'b0;
          state_d     = EMIT;
        end else if (last_cell) begin
          state_d = COMMIT;
        end else begin
          x_d = adv_x;
          y_d = adv_y;
        end
      end
      EMIT: begin
        // Everything holds until the sink accepts the pixel.
        if (plot_ready) begin
          plot_d = 1'b0;
          if (from_load_q) state_d = IDLE;
          else if (last_cell) state_d = COMMIT;
          else begin
            x_d     = adv_x;
            y_d     = adv_y;
            state_d = SCAN;
          end
        end
      end
      COMMIT: begin
        cur_d   = nxt_q;
        gen_d   = gen_q + 16'd1;
        alive_d = alive_nxt_q;
        if (run) begin
          wrap_d  = wrap;
          x_d     = 8'd0;
          y_d     = 8'd0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      nxt_q       <= '0;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      wrap_q      <= 1'b0;
      from_load_q <= 1'b0;
      out_x_q     <= 8'd0;
      out_y_q     <= 8'd0;
      colour_q    <= 3'b000;
      plot_q      <= 1'b0;
      gen_q       <= 16'd0;
      alive_q     <= 16'd0;
      alive_nxt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
      from_load_q <= from_load_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      gen_q       <= gen_d;
      alive_q     <= alive_d;
      alive_nxt_q <= alive_nxt_d;
    end
  end

  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign busy        = (state_q != IDLE);
  assign gen_count   = gen_q;
  assign alive_count = alive_q;
endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 The block SHALL have parameter GRID_W, default 160, meaning grid width in cells (2..256).
REQ-002 The block SHALL have parameter GRID_H, default 120, meaning grid height in cells (2..256).
REQ-003 The block SHALL have parameter ALIVE_COLOUR, default 3'b111, meaning colour emitted for a cell becoming alive; a cell becoming dead is always emitted as 3'b000.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 The block SHALL have port load, input, 1 bit: one-cycle request to write cell (x_in,y_in) with load_val.
REQ-007 The block SHALL have ports x_in [7:0], y_in [7:0] and load_val [0:0], all inputs, giving the load coordinates and value.
REQ-008 The block SHALL have port clear, input, 1 bit: one-cycle request to kill all cells.
REQ-009 The block SHALL have ports step and run, inputs, 1 bit each: step is a one-cycle request for one generation; run is a level requesting continuous generations.
REQ-010 The block SHALL have port wrap, input, 1 bit: 1 selects toroidal edges, 0 selects dead-boundary edges; it is sampled at generation start.
REQ-011 The block SHALL have outputs out_x [7:0], out_y [7:0], colour [2:0] and plot (1 bit), forming the pixel-write stream; plot is the valid signal.
REQ-012 The block SHALL have port plot_ready, input, 1 bit: the pixel sink accepts a write when plot and plot_ready are both 1.
REQ-013 The block SHALL have outputs busy (1 bit), gen_count [15:0] and alive_count [15:0].

Function
REQ-014 Coordinates SHALL be x = column (0..GRID_W-1) and y = row (0..GRID_H-1); state SHALL be held in cur[] and nxt[] bit arrays of GRID_W*GRID_H cells.
REQ-015 The FSM SHALL have the states IDLE, SCAN, EMIT and COMMIT; busy SHALL be 1 in every state except IDLE.
REQ-016 In IDLE, priority SHALL be clear > load > (step or run); lower-priority requests in the same cycle SHALL be dropped.
REQ-017 A clear SHALL zero cur, nxt, gen_count and alive_count in one cycle, emit no plots, and remain in IDLE.
REQ-018 A load with x_in<GRID_W and y_in<GRID_H SHALL write cur[x_in,y_in]=load_val, adjust alive_count only if the cell changes, and enter EMIT with out_x=x_in, out_y=y_in, colour = load_val ? ALIVE_COLOUR : 0; after the EMIT handshake the FSM SHALL return to IDLE.
REQ-019 A load with an out-of-range coordinate SHALL be ignored, with no state change and no plot.
REQ-020 Requests arriving while busy=1 SHALL be ignored, except run, which is a level.
REQ-021 On step, or run=1, in IDLE, the FSM SHALL latch wrap, set the scan index to (0,0) and enter SCAN on the next cycle.
REQ-022 SCAN SHALL evaluate one cell per cycle in row-major order (x fastest), computing nxt = (n==3) | (cur & n==2), where n is the 8-neighbour count from cur.
REQ-023 With wrap=1, neighbour coordinates SHALL be taken modulo GRID_W/GRID_H; with wrap=0, out-of-grid neighbours SHALL count as dead.
REQ-024 If the new value of a cell differs from cur, SCAN SHALL enter EMIT with that cell's coordinates and colour, then resume at the next cell after the handshake.
REQ-025 An unchanged cell SHALL advance the index without stalling.
REQ-026 In EMIT, plot SHALL be 1 and out_x/out_y/colour SHALL be held stable until the cycle in which plot_ready=1, after which plot drops; no other state SHALL change while plot_ready=0.
REQ-027 After the last cell (GRID_W-1,GRID_H-1) is evaluated and any emit for it completes, the FSM SHALL enter COMMIT.
REQ-028 COMMIT SHALL take one cycle: copy nxt to cur, increment gen_count (wrapping 16'hFFFF to 0), and update alive_count.
REQ-029 After COMMIT the FSM SHALL start the next generation directly if run=1, and otherwise return to IDLE.
REQ-030 Deasserting run mid-generation SHALL let the current generation finish.
REQ-031 A generation with k changes and zero stall SHALL take GRID_W*GRID_H + k + 1 busy cycles.

Reset
REQ-032 Reset SHALL asynchronously force state=IDLE, cur=nxt=0, out_x=out_y=0, colour=0, plot=0, busy=0, gen_count=0 and alive_count=0, including mid-SCAN or mid-EMIT.
REQ-033 After reset releases, the first edge SHALL honour requests normally.

Verification (GRID_W=8, GRID_H=8)
REQ-034 The bench SHALL cover a blinker: load (5,4),(5,5),(5,6), then step, wrap=0 -> plots in order (5,4,0),(4,5,7),(6,5,7),(5,6,0); gen_count=1; alive_count=3.
REQ-035 The bench SHALL cover wrap: load (7,3),(0,3),(1,3), then step with wrap=1 -> plots (0,2,7),(1,3,0),(7,3,0),(0,4,7); the same pattern with wrap=0 -> plots (0,3,0),(1,3,0),(7,3,0), alive_count=0.
REQ-036 The bench SHALL cover a block still life: load (2,2),(3,2),(2,3),(3,3), then step -> no plot, busy high exactly 65 cycles, gen_count=1.
REQ-037 The bench SHALL cover backpressure: hold plot_ready=0 for 5 cycles during the first blinker emit -> plot=1 and out_x=5, out_y=4 stable for all 6 cycles, no index advance, and identical final state.
REQ-038 The bench SHALL cover reset mid-SCAN: assert reset at scan index (3,2) -> outputs are zero immediately, cur is all-zero, and a following step produces no plots.
REQ-039 The bench SHALL cover priority: clear+load(1,1)+step in the same IDLE cycle -> grid cleared, no plot, busy=0; load (8,0) -> ignored, with no plot.
